// File: rtl/sidetone_generator.sv
// Keyed square-wave sidetone: IDLE/TONE/TAIL FSM, high half-periods never truncated.
// Optional PWM volume on the high phase when SIDETONE_PWM_VOL_EN is defined.
module sidetone_generator #(
    parameter int unsigned DIV_W = 17,
    parameter int unsigned VOL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dit,
    input  logic             dah,
    input  logic [DIV_W-1:0] half_period,
`ifdef SIDETONE_PWM_VOL_EN
    input  logic [VOL_W-1:0] volume,
`endif
    output logic             tone_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        TAIL = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] hp_lat, hp_n;
    logic [DIV_W-1:0] counter, counter_n;
    logic [DIV_W-1:0] cnt_step, hp_clamped;
    logic             phase, phase_n, ph_step;
    logic             key, wrap, tone_n;

    assign key        = dit | dah;
    assign hp_clamped = (half_period < DIV_W'(2)) ? DIV_W'(2) : half_period;
    assign wrap       = (counter == hp_lat - DIV_W'(1));
    assign cnt_step   = wrap ? '0 : counter + DIV_W'(1);
    assign ph_step    = wrap ? ~phase : phase;

    always_comb begin
        state_n   = state;
        hp_n      = hp_lat;
        counter_n = counter;
        phase_n   = phase;
        unique case (state)
            IDLE: begin
                counter_n = '0;
                phase_n   = 1'b0;
                if (key) begin
                    hp_n    = hp_clamped;
                    phase_n = 1'b1;
                    state_n = TONE;
                end
            end
            TONE: begin
                if (!key && !phase) begin
                    state_n   = IDLE;
                    counter_n = '0;
                    phase_n   = 1'b0;
                end else begin
                    counter_n = cnt_step;
                    phase_n   = ph_step;
                    // Release on the last high cycle already completes the half-period.
                    if (!key)
                        state_n = wrap ? IDLE : TAIL;
                end
            end
            TAIL: begin
                counter_n = cnt_step;
                phase_n   = ph_step;
                if (key)
                    state_n = TONE;
                else if (wrap)
                    state_n = IDLE;
            end
            default: begin
                state_n   = IDLE;
                counter_n = '0;
                phase_n   = 1'b0;
            end
        endcase
    end

`ifdef SIDETONE_PWM_VOL_EN
    logic [VOL_W-1:0] pwm_cnt, pwm_n;

    // PWM counter is held at zero whenever the FSM is, or is about to be, idle.
    assign pwm_n  = (state == IDLE || state_n == IDLE) ? '0 : pwm_cnt + VOL_W'(1);
    assign tone_n = phase_n & (pwm_n < volume);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_n;
    end
`else
    assign tone_n = phase_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hp_lat   <= '0;
            counter  <= '0;
            phase    <= 1'b0;
            tone_out <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            hp_lat   <= hp_n;
            counter  <= counter_n;
            phase    <= phase_n;
            tone_out <= tone_n;
            busy     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_sidetone_generator.sv
// Directed and randomized checks of sidetone_generator against a position-based tone model.
module tb_sidetone_generator;

    localparam int unsigned DIV_W = 17;
    localparam int unsigned VOL_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             dit, dah;
    logic [DIV_W-1:0] half_period;
    logic             tone_out, busy;
`ifdef SIDETONE_PWM_VOL_EN
    logic [VOL_W-1:0] volume = 4'd15;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Model: tone position within one period, cycles since tone start.
    bit m_active = 0;
    int m_pos    = 0;
    int m_hpl    = 2;
    int m_cyc    = 0;
    int highs;

    sidetone_generator #(.DIV_W(DIV_W), .VOL_W(VOL_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dit         (dit),
        .dah         (dah),
        .half_period (half_period),
`ifdef SIDETONE_PWM_VOL_EN
        .volume      (volume),
`endif
        .tone_out    (tone_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    endtask

    function automatic logic exp_tone();
        logic t;
        t = m_active && (m_pos < m_hpl);
`ifdef SIDETONE_PWM_VOL_EN
        t = t && ((m_cyc % (1 << VOL_W)) < int'(volume));
`endif
        return t;
    endfunction

    task automatic model_edge();
        bit key;
        key = dit | dah;
        if (!rst_n) begin
            m_active = 0; m_pos = 0; m_cyc = 0;
        end else if (!m_active) begin
            if (key) begin
                m_active = 1;
                m_hpl    = (half_period < 2) ? 2 : int'(half_period);
                m_pos    = 0;
                m_cyc    = 0;
            end
        end else if (!key && m_pos >= m_hpl) begin
            m_active = 0; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % (2 * m_hpl);
            m_cyc++;
            if (!key && m_pos == m_hpl) begin
                m_active = 0; m_pos = 0;
            end
        end
    endtask

    task automatic step(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check({tag, ".tone"}, tone_out, exp_tone());
            check({tag, ".busy"}, busy, logic'(m_active));
        end
    endtask

    initial begin
        rst_n = 1'b0; dit = 1'b0; dah = 1'b0; half_period = 17'd4;
        #1;
        check("reset_async.tone", tone_out, 1'b0);
        check("reset_async.busy", busy, 1'b0);
        step("reset", 3);
        rst_n = 1'b1;
        step("idle", 3);

        // hp=4, dit held 24 cycles: 4 high / 4 low
        dit = 1'b1;
        highs = 0;
        for (int i = 0; i < 24; i++) begin
            step("hp4", 1);
            highs += int'(tone_out);
        end
        check("hp4_high_count", logic'(highs == 12), 1'b1);
        dit = 1'b0;
        step("hp4_stop", 10);

        // dah released two cycles into a high phase -> tail
        dah = 1'b1;
        step("tail_a", 2);
        dah = 1'b0;
        step("tail_b", 8);

        // dit re-asserted during tail
        dit = 1'b1;
        step("retrig_a", 10);
        dit = 1'b0;
        step("retrig_b", 1);
        dit = 1'b1;
        step("retrig_c", 20);
        dit = 1'b0;
        step("retrig_d", 10);

        // minimum period, and half_period ignored mid-tone
        half_period = 17'd0;
        dah = 1'b1;
        step("hp0", 12);
        dah = 1'b0;
        step("hp0_stop", 6);
        half_period = 17'd5;
        dit = 1'b1;
        step("hp5", 15);
        half_period = 17'd9;
        step("hp5_hold", 15);
        dit = 1'b0;
        step("hp5_stop", 12);
        dit = 1'b1; dah = 1'b1;
        step("hp9", 40);
        dit = 1'b0; dah = 1'b0;
        step("hp9_stop", 20);

        // async reset mid-high-phase, key still high across release
        half_period = 17'd6;
        dit = 1'b1;
        step("rst_mid", 3);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_async.tone", tone_out, 1'b0);
        check("rst_mid_async.busy", busy, 1'b0);
        m_active = 0; m_pos = 0; m_cyc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_restart", 16);
        dit = 1'b0;
        step("rst_restart_stop", 14);

`ifdef SIDETONE_PWM_VOL_EN
        half_period = 17'd40;
        volume = 4'd4;
        dit = 1'b1;
        step("pwm4", 100);
        dit = 1'b0;
        step("pwm4_stop", 50);
        volume = 4'd0;
        dit = 1'b1;
        step("pwm0", 60);
        dit = 1'b0;
        step("pwm0_stop", 50);
        volume = 4'd15;
`endif

        // randomized keying and half_period
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) dit = ~dit;
            if ($urandom_range(0, 9) == 0) dah = ~dah;
            if ($urandom_range(0, 15) == 0) half_period = DIV_W'($urandom_range(0, 7));
`ifdef SIDETONE_PWM_VOL_EN
            if ($urandom_range(0, 31) == 0) volume = VOL_W'($urandom_range(0, 15));
`endif
            step("rand", 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sidetone_generator.md
SIDETONE_GENERATOR -- requirements
Module: sidetone_generator

Interface
REQ-001 SHALL have parameter: DIV_W, 17, width of the half-period counter and of half_period.
REQ-002 SHALL have parameter: VOL_W, 4, width of volume and of the PWM counter (used only with SIDETONE_PWM_VOL_EN).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: dit  input  1  key request; a tone is requested while dit or dah is high.
REQ-006 SHALL have port: dah  input  1  key request; ORed with dit.
REQ-007 SHALL have port: half_period  input  DIV_W  tone half-period in clk cycles (600 Hz at 50 MHz = 41667).
REQ-008 SHALL have port: volume  input  VOL_W  PWM duty for the tone high phase (present only with SIDETONE_PWM_VOL_EN).
REQ-009 SHALL have port: tone_out  output  1  registered square-wave tone.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement key = dit | dah and a three-state FSM: IDLE, TONE, TAIL.
REQ-012 SHALL hold hp_lat (DIV_W), counter (DIV_W), phase (1 bit) and state registers.
REQ-013 SHALL, in IDLE with key=1, latch hp_lat = max(half_period, 2), set counter=0, set phase=1 and enter TONE; tone_out goes high on the edge after key is first sampled high.
REQ-014 SHALL, in TONE or TAIL, increment counter each cycle; when counter == hp_lat-1, counter -> 0 and phase toggles, giving a period of exactly 2*hp_lat cycles.
REQ-015 SHALL ignore changes on half_period outside IDLE; a new value takes effect only at the next IDLE->TONE transition.
REQ-016 SHALL, in TONE with key=0 and phase=0, go to IDLE with counter cleared, so the tone never restarts mid-low-phase.
REQ-017 SHALL, in TONE with key=0 and phase=1, enter TAIL and complete the current high half-period without truncation.
REQ-018 SHALL, in TAIL, return to IDLE with phase=0 and counter=0 when counter == hp_lat-1; key=1 during TAIL returns to TONE with counter and phase kept, so the waveform stays continuous.
REQ-019 SHALL treat half_period values 0 and 1 as 2 (minimum period 4 cycles).
REQ-020 SHALL drive tone_out = phase (registered), except as modified by REQ-025.
REQ-021 SHALL drive busy high in TONE and TAIL and low in IDLE.
REQ-022 SHALL, when dit and dah rise in the same cycle, behave as a single key assertion.

Reset
REQ-023 SHALL, on rst_n=0 (asynchronous, any state, including mid-tone), set state=IDLE, counter=0, hp_lat=0, phase=0, tone_out=0 and busy=0.
REQ-024 SHALL, after rst_n deasserts with key already high, start a tone on the first clock edge per REQ-013.

Configuration
REQ-025 SHALL, with SIDETONE_PWM_VOL_EN defined:
  - add the volume port and a free-running VOL_W pwm counter (reset 0);
  - drive tone_out = phase & (pwm_cnt < volume);
  - keep pwm_cnt clear and frozen in IDLE, so volume=0 gives silence.
REQ-026 SHALL, without SIDETONE_PWM_VOL_EN, omit the volume port and PWM logic, with tone_out = phase.

Verification
REQ-027 SHALL cover: half_period=4, dit high for 24 cycles -> tone_out high 4 / low 4 repeating from cycle 1; busy high throughout.
REQ-028 SHALL cover: half_period=4, dah released 2 cycles into a high phase -> TAIL; tone_out stays high 2 more cycles, then 0, then busy=0.
REQ-029 SHALL cover: dit re-asserted during TAIL -> tone continues with no phase glitch; period stays 8 cycles.
REQ-030 SHALL cover:
  - half_period=0 -> period 4 cycles;
  - half_period changed 5->9 mid-tone -> period stays 10 until IDLE, then 18 on the next tone.
REQ-031 SHALL cover: rst_n pulsed low mid-high-phase -> tone_out=0 and busy=0 immediately, without waiting for a clock edge.
REQ-032 SHALL cover, with SIDETONE_PWM_VOL_EN, VOL_W=4:
  - volume=4 -> tone_out high 4 of every 16 cycles within each high phase;
  - volume=0 -> tone_out constant 0.
